// File: rtl/axi4_lite_regfile_pkg.sv
// axi4_lite_pkg: shared constants and helpers for the AXI4-Lite register file.
//   OKAY / SLVERR    : AXI response codes.
//   DECODE_ERR_DATA  : read data returned for out-of-range addresses.
//   idx_width()      : bits needed to index NUM_REGS registers (minimum 1).
package axi4_lite_pkg;

  localparam logic [1:0]  OKAY            = 2'b00;
  localparam logic [1:0]  SLVERR          = 2'b10;
  localparam logic [31:0] DECODE_ERR_DATA = 32'h0DEC0DE0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_if.sv
// axi4_lite_regfile_if: AXI4-Lite bus bundle.
//   Parameters DW (data width) and AW (byte-address width).
//   Modports: master (drives requests), slave (drives ready/response).
interface axi4_lite_regfile_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_regfile_strb_merge.sv
// axi4_lite_strb_merge: combinational byte-lane merge.
//   old_word : current register contents
//   new_word : write data
//   strb     : per-byte enable; set lanes take new_word, clear lanes keep old_word
//   merged   : result
module axi4_lite_strb_merge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   merged
);
  always_comb begin
    merged = old_word;
    for (int unsigned b = 0; b < DW / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
  end
endmodule

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: AXI4-Lite slave with NUM_REGS word registers.
//   AXI_ACLK / AXI_ARESETN : clock, asynchronous active-low reset
//   s_axi                  : AXI4-Lite slave bus (axi4_lite_regfile_if.slave)
//   ctrl_out               : stored registers, slice i = [i*DW +: DW]; read-only slices 0
//   status_in              : read values for read-only registers (RO_MASK bits)
//   wr_pulse / rd_pulse    : one-cycle strobe per register on successful write/read
// Optional: define AXI4_LITE_REGFILE_WSTRB_EN to honour WSTRB per byte lane;
// otherwise every write replaces the whole word.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned         AXI_DATA_WIDTH = 32,
  parameter int unsigned         AXI_ADDR_WIDTH = 8,
  parameter int unsigned         NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                               AXI_ACLK,
  input  logic                               AXI_ARESETN,
  axi4_lite_regfile_if.slave                 s_axi,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                wr_pulse,
  output logic [NUM_REGS-1:0]                rd_pulse
);
  localparam int unsigned DW  = AXI_DATA_WIDTH;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned LSB = $clog2(SW);
  localparam int unsigned RIW = idx_width(NUM_REGS);

  logic [DW-1:0]             regs [NUM_REGS];
  logic                      aw_held, w_held, bvalid_q, rvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]             w_data_q, rdata_q, wr_word;
  logic [1:0]                bresp_q, rresp_q;
  logic [SW-1:0]             cur_wstrb;
  logic [AXI_ADDR_WIDTH-1:0] cur_awaddr;
  logic [DW-1:0]             cur_wdata;
  logic                      aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0]               wr_index, rd_index;
  logic [RIW-1:0]            wr_ridx, rd_ridx;
  logic                      wr_ok, rd_in_range;

  assign s_axi.S_AXI_AWREADY = ~aw_held & ~bvalid_q;
  assign s_axi.S_AXI_WREADY  = ~w_held & ~bvalid_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = ~rvalid_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign aw_hs = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  // A write completes once both halves are available, held or arriving now.
  assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs);

  assign cur_awaddr = aw_held ? aw_addr_q : s_axi.S_AXI_AWADDR;
  assign cur_wdata  = w_held ? w_data_q : s_axi.S_AXI_WDATA;

  always_comb begin
    wr_index = 32'(cur_awaddr >> LSB);
    rd_index = 32'(s_axi.S_AXI_ARADDR >> LSB);
    wr_ridx  = wr_index[RIW-1:0];
    rd_ridx  = rd_index[RIW-1:0];
    wr_ok       = (wr_index < NUM_REGS) && !RO_MASK[wr_ridx];
    rd_in_range = (rd_index < NUM_REGS);
  end

`ifdef AXI4_LITE_REGFILE_WSTRB_EN
  logic [SW-1:0] w_strb_q;
  logic [DW-1:0] old_word;
  logic          unused_sink;

  assign cur_wstrb = w_held ? w_strb_q : s_axi.S_AXI_WSTRB;
  assign old_word  = regs[wr_ridx];

  axi4_lite_strb_merge #(.DW(DW)) u_strb_merge (
    .old_word (old_word),
    .new_word (cur_wdata),
    .strb     (cur_wstrb),
    .merged   (wr_word)
  );

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN)                 w_strb_q <= '0;
    else if (w_hs && !wr_fire)        w_strb_q <= s_axi.S_AXI_WSTRB;
  end

  assign unused_sink = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
`else
  logic unused_sink;
  assign cur_wstrb   = '1;
  assign wr_word     = cur_wdata;
  assign unused_sink = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_WSTRB, cur_wstrb};
`endif

  // Write path: independent AW/W holds, B response, register update.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      wr_pulse  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) begin
          regs[wr_ridx]     <= wr_word;
          wr_pulse[wr_ridx] <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.S_AXI_WDATA;
        end
      end
    end
  end

  // Read path: fully independent of the write path; sees pre-write contents.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      rd_pulse <= '0;
    end else begin
      rd_pulse <= '0;
      if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        if (!rd_in_range) begin
          rdata_q <= DW'(DECODE_ERR_DATA);
          rresp_q <= SLVERR;
        end else begin
          rdata_q <= RO_MASK[rd_ridx] ? status_in[rd_ridx*DW +: DW] : regs[rd_ridx];
          rresp_q <= OKAY;
          rd_pulse[rd_ridx] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) ctrl_out[i*DW +: DW] = regs[i];
    end
  end

endmodule

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Parametrised AXI4-Lite slave exposing NUM_REGS word-wide registers to a master, with per-register read-only marking, decode-error responses and independent AW/W channel acceptance. It replaces hand-written per-design slaves: control registers drive fabric logic through `ctrl_out`, read-only registers reflect `status_in`, and one-cycle strobes tell the fabric when a register was written or read.

## Interface
- `AXI_DATA_WIDTH`, 32: data width, 32 or 64.
- `AXI_ADDR_WIDTH`, 8: byte-address width; must satisfy 2^(AXI_ADDR_WIDTH-log2(AXI_DATA_WIDTH/8)) >= NUM_REGS.
- `NUM_REGS`, 16: number of registers, 1..256.
- `RO_MASK`, 0: NUM_REGS-bit mask; a set bit i makes register i read-only, sourced from `status_in`.

Ports:
- `AXI_ACLK` in 1: single clock. Reset is asynchronous and active-low.
- `AXI_ARESETN` in 1: asynchronous, active-low reset.
- `S_AXI_AWADDR`/`AWVALID`/`AWPROT` in; `S_AXI_AWREADY` out: write address channel. AWPROT is ignored.
- `S_AXI_WDATA`/`WSTRB`/`WVALID` in; `S_AXI_WREADY` out: write data channel.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1: write response.
- `S_AXI_ARADDR`/`ARVALID`/`ARPROT` in; `S_AXI_ARREADY` out: read address channel. ARPROT is ignored.
- `S_AXI_RDATA` out DW; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1: read data.
- `ctrl_out` out NUM_REGS*DW: register i occupies bits [i*DW +: DW]. Slices for read-only registers are driven 0.
- `status_in` in NUM_REGS*DW: read value for read-only registers. Sampled on the AR handshake edge.
- `wr_pulse` out NUM_REGS: one-cycle pulse on a successful write to register i.
- `rd_pulse` out NUM_REGS: one-cycle pulse on a successful read of register i.

## Operation
- **Address decode:** index = addr >> log2(DW/8). Low byte-offset bits are ignored.
- **Write channel:** AW and W are accepted independently, each into a one-entry holding flag/register.
  - AWREADY = ~aw_held & ~BVALID. WREADY = ~w_held & ~BVALID.
  - A write executes on the edge where both are available: held, or handshaking that cycle. That edge clears both holds and sets BVALID.
- **Write result:**
  - index >= NUM_REGS → SLVERR, no register change, no pulse.
  - RO_MASK[index] set → SLVERR, no change, no pulse.
  - Otherwise OKAY; register updated; wr_pulse[index] = 1 for one cycle.
- **Write response:** BVALID holds until BREADY; it clears on the B handshake edge. AWREADY/WREADY return high the following cycle.
- **Read channel:** ARREADY = ~RVALID. On the AR handshake edge, RDATA/RRESP are registered, RVALID is set, and rd_pulse[index] pulses for valid indices.
  - Read-only registers return `status_in`; other registers return the stored value.
  - Out of range → RDATA = 0x0DEC0DE0, zero-extended; RRESP = SLVERR.
  - RVALID holds until RREADY.
- **Read/write ordering:** read and write paths are fully concurrent. A read and a write to the same register on the same edge: the read returns the old value.
- **Reset values:** all stored registers 0; AWREADY/WREADY/ARREADY 1 after reset deasserts; BVALID/RVALID 0; BRESP/RRESP 0; RDATA 0; pulses 0.
- **Reset mid-transaction:** all holds and pending responses are dropped immediately, asynchronously.

## Timing
- Write latency: BVALID rises on the edge of the completing handshake, i.e. is high in the next cycle. AW and W in the same cycle → BVALID the next cycle.
- Read latency: RVALID high the cycle after the AR handshake.
- Throughput: one write per 2 cycles with BREADY tied high; one read per 2 cycles.
- ctrl_out reflects a write in the cycle after the write edge, coincident with wr_pulse.

## Configuration
- `AXI4_LITE_REGFILE_WSTRB_EN` defined: WSTRB is honoured per byte lane. Lanes with a clear strobe keep their old byte. WSTRB = 0 is an OKAY no-op write that still pulses wr_pulse.
- Undefined: WSTRB is ignored and every write replaces the full word.

## Structure
- Package `axi4_lite_pkg` holds:
  - response constants OKAY = 2'b00 and SLVERR = 2'b10;
  - DECODE_ERR_DATA = 32'h0DEC0DE0;
  - the index-width function (clog2 of NUM_REGS).
- Sub-module `axi4_lite_strb_merge`: combinational old/new word merge by WSTRB. Instantiated only under the macro.

## Test plan
- Write 0xA5A5_1234 to 0x08, then read 0x08 → BRESP OKAY; wr_pulse[2] is a single cycle; RDATA 0xA5A5_1234, RRESP OKAY; ctrl_out slice 2 = 0xA5A5_1234.
- W presented 3 cycles before AW (address 0x04, data 0x11) → WREADY drops after the W handshake; BVALID appears the cycle after AW; register 1 = 0x11.
- RO_MASK = 0x1, status_in[0] = 0xCAFE; write 0x00, then read 0x00 → BRESP SLVERR, no wr_pulse; RDATA 0xCAFE, OKAY.
- NUM_REGS = 16; read 0x40 and write 0x40 → RRESP SLVERR with RDATA 0x0DEC0DE0; BRESP SLVERR; no pulses.
- With the macro defined: register 3 = 0xFFFF_FFFF, write 0x0 with WSTRB 4'b0101 → register 3 = 0xFF00_FF00. Without the macro: register 3 = 0x0.
- BREADY held low for 5 cycles, then AXI_ARESETN pulsed low mid-response → BVALID 0 immediately; registers 0; ready signals 1 after release.
